acc_flag_unit: RTL and testbench
================================

ACC_FLAG_UNIT -- requirements
Module: acc_flag_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have ports: req_valid  in  1  operation request; req_ready  out  1  unit can accept.
REQ-004 SHALL have ports: req_op2  in  8  second operand; req_ctrl  in  3  ALU op (000 ADD, 001 SUB, 010 RLC, 011 RRC, 100 ANA, 101 ORA, 110 XRA, 111 CMA).
REQ-005 SHALL have ports: acc_load  in  1  direct accumulator write; acc_din  in  8  load data.
REQ-006 SHALL have ports: alu_op1  out  8, alu_op2  out  8, alu_ctrl  out  3  drive the downstream ALU; alu_out  in  8  ALU result.
REQ-007 SHALL have ports: acc  out  8  accumulator; flags  out  8  {S,Z,0,AC,0,P,1,CY}; done  out  1  one-cycle commit pulse.

Function
REQ-008 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; one operation in flight; throughput one per 3 cycles.
REQ-009 SHALL assert req_ready only in IDLE with acc_load low; request accepted on the edge where req_valid && req_ready, latching req_op2/req_ctrl and entering EXEC.
REQ-010 SHALL, in EXEC, drive alu_op1=acc, alu_op2=latched op2, alu_ctrl=latched ctrl; in other states drive alu_op1=acc, alu_op2=0, alu_ctrl=000.
REQ-011 SHALL, on the EXEC->DONE edge, write acc<=alu_out and update flags; done=1 throughout DONE only; latency accept edge to done high = 2 cycles.
REQ-012 SHALL compute S=result[7], Z=(result==0), P=even parity of result, for ADD/SUB/ANA/ORA/XRA.
REQ-013 SHALL compute CY: ADD carry out of 9-bit sum; SUB borrow (op1<op2); RLC old acc[7]; RRC old acc[0]; ANA/ORA/XRA 0.
REQ-014 SHALL, for RLC/RRC, update only CY; for CMA, leave all flags unchanged.
REQ-015 SHALL, in IDLE, write acc<=acc_din on acc_load, flags unchanged; acc_load in EXEC/DONE ignored.
REQ-016 SHALL give acc_load priority over req_valid in the same IDLE cycle; request remains pending (req_ready low) and is accepted on a later cycle.
REQ-017 SHALL keep flag bits 5 and 3 at 0 and bit 1 at 1 at all times.

Reset
REQ-018 SHALL, on rst asserted in any state, immediately force state=IDLE, acc=8'h00, flags=8'h02, done=0, latched op2=0, ctrl=000; an in-flight operation is discarded without commit.
REQ-019 SHALL assert req_ready in the first cycle after rst deasserts (acc_load low).

Configuration
REQ-020 SHALL, with AUX_CARRY_EN defined, compute AC: ADD carry out of bit 3; SUB low-nibble borrow (op1[3:0]<op2[3:0]); ANA 1; ORA/XRA 0; RLC/RRC/CMA unchanged.
REQ-021 SHALL, without AUX_CARRY_EN, hold flag bit 4 at 0 permanently.

Structure
REQ-022 SHALL place ctrl encodings, FSM state enum, flag bit positions and reset flag value (8'h02) in shared package acc_flag_pkg.
REQ-023 SHALL compute flags in combinational sub-module flag_gen (inputs old acc, op2, ctrl, alu_out, old flags; output next flags).

Verification
REQ-024 SHALL verify reset: rst pulse -> acc=00, flags=02, done=0, req_ready=1 after release.
REQ-025 SHALL verify ADD: load 3A, ADD op2 C6 -> acc=00, flags=57 (AUX_CARRY_EN) / 47 (without), done 2 cycles after accept.
REQ-026 SHALL verify SUB: load 05, SUB op2 07 -> acc=FE, flags=93 (AUX_CARRY_EN) / 83 (without).
REQ-027 SHALL verify rotate/CMA: flags=57, load 81, RLC -> acc=03, flags=57; then CMA -> acc=FC, flags=57.
REQ-028 SHALL verify collision: acc_load=1 (din 10) and req_valid=1 (ADD 01) in same IDLE cycle -> acc=10, req_ready=0 that cycle; ADD accepted next cycle -> acc=11.
REQ-029 SHALL verify reset mid-operation: rst asserted during EXEC -> no done pulse, acc=00, flags=02.

Source files
------------

// File: rtl/acc_flag_pkg.sv
// Shared definitions for the accumulator/flag unit: ALU control encodings,
// FSM states, flag bit positions and the reset value of the flag register.
package acc_flag_pkg;

   typedef enum logic [2:0] {
      CTRL_ADD = 3'b000,
      CTRL_SUB = 3'b001,
      CTRL_RLC = 3'b010,
      CTRL_RRC = 3'b011,
      CTRL_ANA = 3'b100,
      CTRL_ORA = 3'b101,
      CTRL_XRA = 3'b110,
      CTRL_CMA = 3'b111
   } ctrl_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Flag register layout {S,Z,0,AC,0,P,1,CY}
   localparam int FLAG_S   = 7;
   localparam int FLAG_Z   = 6;
   localparam int FLAG_Z5  = 5;
   localparam int FLAG_AC  = 4;
   localparam int FLAG_Z3  = 3;
   localparam int FLAG_P   = 2;
   localparam int FLAG_ONE = 1;
   localparam int FLAG_CY  = 0;

   localparam logic [7:0] FLAGS_RESET = 8'h02;

   // P flag is set when the result holds an even number of ones
   function automatic logic even_parity(input logic [7:0] v);
      return ~(^v);
   endfunction

endpackage

// File: rtl/acc_flag_unit_flag_gen.sv
// Combinational next-flag generator. Aux-carry support is compiled in only
// when AUX_CARRY_EN is defined; otherwise flag bit 4 is held at 0.
module flag_gen
   import acc_flag_pkg::*;
(
   input  logic [7:0] acc_old,
   input  logic [7:0] op2,
   input  logic [2:0] ctrl,
   input  logic [7:0] alu_out,
   input  logic [7:0] flags_old,
   output logic [7:0] flags_next
);

   logic carry_add;
   logic borrow_sub;
   assign carry_add  = ((9'(acc_old) + 9'(op2)) >= 9'd256);
   assign borrow_sub = (acc_old < op2);

`ifdef AUX_CARRY_EN
   logic half_carry;
   logic half_borrow;
   assign half_carry  = ((5'(acc_old[3:0]) + 5'(op2[3:0])) >= 5'd16);
   assign half_borrow = (acc_old[3:0] < op2[3:0]);
`endif

   // Select which flags each operation touches; fixed bits forced last
   always_comb begin
      flags_next = flags_old;
      case (ctrl)
         CTRL_ADD, CTRL_SUB, CTRL_ANA, CTRL_ORA, CTRL_XRA: begin
            flags_next[FLAG_S] = alu_out[7];
            flags_next[FLAG_Z] = (alu_out == 8'h00);
            flags_next[FLAG_P] = even_parity(alu_out);
            if (ctrl == CTRL_ADD)
               flags_next[FLAG_CY] = carry_add;
            else if (ctrl == CTRL_SUB)
               flags_next[FLAG_CY] = borrow_sub;
            else
               flags_next[FLAG_CY] = 1'b0;
`ifdef AUX_CARRY_EN
            if (ctrl == CTRL_ADD)
               flags_next[FLAG_AC] = half_carry;
            else if (ctrl == CTRL_SUB)
               flags_next[FLAG_AC] = half_borrow;
            else if (ctrl == CTRL_ANA)
               flags_next[FLAG_AC] = 1'b1;
            else
               flags_next[FLAG_AC] = 1'b0;
`endif
         end
         CTRL_RLC: flags_next[FLAG_CY] = acc_old[7];
         CTRL_RRC: flags_next[FLAG_CY] = acc_old[0];
         default:  flags_next = flags_old;
      endcase
`ifndef AUX_CARRY_EN
      flags_next[FLAG_AC] = 1'b0;
`endif
      flags_next[FLAG_Z5]  = 1'b0;
      flags_next[FLAG_Z3]  = 1'b0;
      flags_next[FLAG_ONE] = 1'b1;
   end

endmodule

// File: rtl/acc_flag_unit.sv
// Accumulator + flag register sequencing one external-ALU operation at a
// time (IDLE -> EXEC -> DONE). Optional aux-carry flag: define AUX_CARRY_EN.
module acc_flag_unit
   import acc_flag_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] req_op2,
   input  logic [2:0] req_ctrl,
   input  logic       acc_load,
   input  logic [7:0] acc_din,
   output logic [7:0] alu_op1,
   output logic [7:0] alu_op2,
   output logic [2:0] alu_ctrl,
   input  logic [7:0] alu_out,
   output logic [7:0] acc,
   output logic [7:0] flags,
   output logic       done
);

   state_e     state_reg, state_next;
   logic [7:0] acc_reg;
   logic [7:0] flags_reg;
   logic [7:0] op2_reg;
   logic [2:0] ctrl_reg;
   logic [7:0] flags_next;
   logic       accept;

   // A direct load wins over a request in the same IDLE cycle
   assign req_ready = (state_reg == ST_IDLE) && !acc_load;
   assign accept    = req_valid && req_ready;
   assign acc       = acc_reg;
   assign flags     = flags_reg;
   assign done      = (state_reg == ST_DONE);

   flag_gen u_flag_gen (
      .acc_old    (acc_reg),
      .op2        (op2_reg),
      .ctrl       (ctrl_reg),
      .alu_out    (alu_out),
      .flags_old  (flags_reg),
      .flags_next (flags_next)
   );

   // State, accumulator, flags and latched request registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         acc_reg   <= 8'h00;
         flags_reg <= FLAGS_RESET;
         op2_reg   <= 8'h00;
         ctrl_reg  <= 3'b000;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_IDLE && acc_load)
            acc_reg <= acc_din;
         else if (state_reg == ST_EXEC) begin
            acc_reg   <= alu_out;
            flags_reg <= flags_next;
         end
         if (accept) begin
            op2_reg  <= req_op2;
            ctrl_reg <= req_ctrl;
         end
      end
   end

   // Next-state and ALU drive; operands only presented during EXEC
   always_comb begin
      state_next = state_reg;
      alu_op1    = acc_reg;
      alu_op2    = 8'h00;
      alu_ctrl   = 3'b000;
      case (state_reg)
         ST_IDLE: if (accept) state_next = ST_EXEC;
         ST_EXEC: begin
            alu_op2    = op2_reg;
            alu_ctrl   = ctrl_reg;
            state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_acc_flag_unit.sv
// Directed self-checking bench for acc_flag_unit with a behavioural ALU and
// a scoreboard of expected {acc,flags} popped on each done pulse.
module tb_acc_flag_unit;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] req_op2 = 8'h00;
   logic [2:0] req_ctrl = 3'b000;
   logic       acc_load = 1'b0;
   logic [7:0] acc_din = 8'h00;
   logic [7:0] alu_op1, alu_op2, alu_out;
   logic [2:0] alu_ctrl;
   logic [7:0] acc, flags;
   logic       done;

   int n_checks = 0;
   int n_pass   = 0;
   logic [15:0] sb_q[$];

`ifdef AUX_CARRY_EN
   localparam logic [7:0] F_ADD = 8'h57;
   localparam logic [7:0] F_SUB = 8'h93;
`else
   localparam logic [7:0] F_ADD = 8'h47;
   localparam logic [7:0] F_SUB = 8'h83;
`endif

   acc_flag_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op2(req_op2), .req_ctrl(req_ctrl), .acc_load(acc_load),
      .acc_din(acc_din), .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_ctrl(alu_ctrl), .alu_out(alu_out), .acc(acc), .flags(flags),
      .done(done)
   );

   always #5 clk = ~clk;

   // Behavioural downstream ALU
   always_comb begin
      alu_out = 8'h00;
      case (alu_ctrl)
         3'b000: alu_out = alu_op1 + alu_op2;
         3'b001: alu_out = alu_op1 - alu_op2;
         3'b010: alu_out = {alu_op1[6:0], alu_op1[7]};
         3'b011: alu_out = {alu_op1[0], alu_op1[7:1]};
         3'b100: alu_out = alu_op1 & alu_op2;
         3'b101: alu_out = alu_op1 | alu_op2;
         3'b110: alu_out = alu_op1 ^ alu_op2;
         default: alu_out = ~alu_op1;
      endcase
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard consumer: every done pulse must match the oldest entry
   always @(negedge clk) begin
      if (done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 8'(done), 8'h00);
         end else begin
            logic [15:0] e;
            e = sb_q.pop_front();
            check("sb_acc", acc, e[15:8]);
            check("sb_flags", flags, e[7:0]);
            $display("txn: done acc=%02h flags=%02h", acc, flags);
         end
      end
   end

   task automatic load(input logic [7:0] d);
      acc_load = 1'b1;
      acc_din  = d;
      tick();
      acc_load = 1'b0;
      check("load_acc", acc, d);
   endtask

   // Issue one request and check handshake, ALU drive and done timing
   task automatic do_op(input logic [2:0] c, input logic [7:0] b,
                        input logic [7:0] old_acc,
                        input logic [7:0] exp_acc, input logic [7:0] exp_flags);
      req_valid = 1'b1;
      req_ctrl  = c;
      req_op2   = b;
      #1;
      check("ready_before_accept", 8'(req_ready), 8'h01);
      sb_q.push_back({exp_acc, exp_flags});
      tick();
      req_valid = 1'b0;
      check("exec_done_low", 8'(done), 8'h00);
      check("exec_alu_op1", alu_op1, old_acc);
      check("exec_alu_op2", alu_op2, b);
      check("exec_alu_ctrl", 8'(alu_ctrl), 8'(c));
      check("exec_ready_low", 8'(req_ready), 8'h00);
      tick();
      check("done_latency", 8'(done), 8'h01);
      check("done_alu_op2_zero", alu_op2, 8'h00);
      tick();
      check("done_one_cycle", 8'(done), 8'h00);
      check("ready_after_done", 8'(req_ready), 8'h01);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      rst = 1'b1;
      tick(); tick();
      check("rst_acc", acc, 8'h00);
      check("rst_flags", flags, 8'h02);
      check("rst_done", 8'(done), 8'h00);
      rst = 1'b0;
      #1;
      check("rst_ready", 8'(req_ready), 8'h01);
      tick();

      // ADD 3A + C6
      load(8'h3A);
      check("load_flags_kept", flags, 8'h02);
      do_op(3'b000, 8'hC6, 8'h3A, 8'h00, F_ADD);

      // SUB 05 - 07
      load(8'h05);
      do_op(3'b001, 8'h07, 8'h05, 8'hFE, F_SUB);

      // Rotate and complement with flags primed by the ADD
      load(8'h3A);
      do_op(3'b000, 8'hC6, 8'h3A, 8'h00, F_ADD);
      load(8'h81);
      check("load_keeps_flags", flags, F_ADD);
      do_op(3'b010, 8'h00, 8'h81, 8'h03, F_ADD);
      do_op(3'b111, 8'h00, 8'h03, 8'hFC, F_ADD);

      // Load/request collision in the same IDLE cycle
      acc_load  = 1'b1;
      acc_din   = 8'h10;
      req_valid = 1'b1;
      req_ctrl  = 3'b000;
      req_op2   = 8'h01;
      #1;
      check("collide_ready_low", 8'(req_ready), 8'h00);
      tick();
      check("collide_acc", acc, 8'h10);
      acc_load = 1'b0;
      #1;
      check("collide_ready_next", 8'(req_ready), 8'h01);
      sb_q.push_back({8'h11, 8'h06});
      tick();
      req_valid = 1'b0;
      acc_load  = 1'b1;      // must be ignored in EXEC and DONE
      acc_din   = 8'hAA;
      check("collide_exec_op1", alu_op1, 8'h10);
      tick();
      check("collide_done", 8'(done), 8'h01);
      tick();
      acc_load = 1'b0;
      check("collide_final_acc", acc, 8'h11);

      // Reset during EXEC discards the operation
      req_valid = 1'b1;
      req_ctrl  = 3'b000;
      req_op2   = 8'h01;
      tick();
      req_valid = 1'b0;
      check("midop_in_exec", alu_op2, 8'h01);
      rst = 1'b1;
      #1;
      check("midop_acc", acc, 8'h00);
      check("midop_flags", flags, 8'h02);
      check("midop_done", 8'(done), 8'h00);
      tick();
      rst = 1'b0;
      #1;
      check("midop_ready", 8'(req_ready), 8'h01);
      tick();
      check("midop_no_done1", 8'(done), 8'h00);
      tick();
      check("midop_no_done2", 8'(done), 8'h00);
      check("midop_acc_after", acc, 8'h00);
      check("sb_empty", 8'(sb_q.size()), 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
